br_resolve_unit: RTL and testbench

BR_RESOLVE_UNIT -- requirements
Module: br_resolve_unit

---
 rtl/br_resolve_unit_if.sv | 28 ++
 rtl/br_resolve_unit.sv | 138 +++++++++++++
 tb/tb_br_resolve_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/br_resolve_unit_if.sv
// rtl/br_resolve_unit_if.sv - input/output handshake bundle for br_resolve_unit
interface br_resolve_unit_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [31:0]       in_pc;
    logic              in_pred;
    logic [DATA_W-1:0] in_rdata1;
    logic [DATA_W-1:0] in_rdata2;
    logic              out_valid;
    logic              out_ready;
    logic              out_taken;
    logic              out_mispredict;
    logic              out_link;
    logic [31:0]       out_target;

    modport master (
        output in_valid, in_instr, in_pc, in_pred, in_rdata1, in_rdata2, out_ready,
        input  in_ready, out_valid, out_taken, out_mispredict, out_link, out_target
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_pred, in_rdata1, in_rdata2, out_ready,
        output in_ready, out_valid, out_taken, out_mispredict, out_link, out_target
    );
endinterface

// File: rtl/br_resolve_unit.sv
// rtl/br_resolve_unit.sv - branch resolve stage with one-entry output register
// Optional 2-bit BHT predictor enabled by defining BR_RESOLVE_BHT_EN.
module br_resolve_unit #(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    br_resolve_unit_if.slave bus,
    input  logic             flush,
    input  logic [31:0]      q_pc,
    output logic             q_taken
);
    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        is_br;
    logic        taken;
    logic        link;
    logic        pred_eff;
    logic        a_neg;
    logic        a_zero;
    logic [31:0] target;
    logic        in_ready;
    logic        pop;

    logic        v_q;
    logic        taken_q;
    logic        mis_q;
    logic        link_q;
    logic        br_q;
    logic [31:0] target_q;
    logic [31:0] pc_q;

    assign opcode = bus.in_instr[31:26];
    assign rt     = bus.in_instr[20:16];
    assign imm    = bus.in_instr[15:0];
    assign a_neg  = bus.in_rdata1[DATA_W-1];
    assign a_zero = (bus.in_rdata1 == '0);

    always_comb begin
        is_br = 1'b1;
        taken = 1'b0;
        link  = 1'b0;
        case (opcode)
            6'b000100: taken = (bus.in_rdata1 == bus.in_rdata2);
            6'b000101: taken = (bus.in_rdata1 != bus.in_rdata2);
            6'b000110: taken = a_neg || a_zero;
            6'b000111: taken = !a_neg && !a_zero;
            6'b000001: begin
                case (rt)
                    5'b00000: taken = a_neg;
                    5'b00001: taken = !a_neg;
                    5'b10001: begin
                        taken = !a_neg;
                        link  = 1'b1;
                    end
                    default: is_br = 1'b0;
                endcase
            end
            default: is_br = 1'b0;
        endcase
    end

    assign target   = bus.in_pc + 32'd4 + (taken ? {{14{imm[15]}}, imm, 2'b00} : 32'd0);
    assign in_ready = !v_q || bus.out_ready;
    assign pop      = v_q && bus.out_ready && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q      <= 1'b0;
            taken_q  <= 1'b0;
            mis_q    <= 1'b0;
            link_q   <= 1'b0;
            br_q     <= 1'b0;
            target_q <= 32'd0;
            pc_q     <= 32'd0;
        end else if (flush) begin
            v_q <= 1'b0;
        end else if (in_ready) begin
            v_q <= bus.in_valid;
            if (bus.in_valid) begin
                taken_q  <= taken;
                mis_q    <= is_br && (taken != pred_eff);
                link_q   <= link;
                br_q     <= is_br;
                target_q <= target;
                pc_q     <= bus.in_pc;
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = v_q;
    assign bus.out_taken      = taken_q;
    assign bus.out_mispredict = mis_q;
    assign bus.out_link       = link_q;
    assign bus.out_target     = target_q;

`ifdef BR_RESOLVE_BHT_EN
    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] q_idx;
    logic             unused_bits;

    assign upd_idx  = pc_q[IDX_W+1:2];
    assign q_idx    = q_pc[IDX_W+1:2];
    // Query reads the registered counter, so a same-cycle update is not visible yet.
    assign q_taken  = bht[q_idx][1];
    assign pred_eff = bus.in_pred;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (pop && br_q) begin
            if (taken_q) begin
                if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else begin
                if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end

    assign unused_bits = ^{q_pc[31:IDX_W+2], q_pc[1:0], pc_q[31:IDX_W+2], pc_q[1:0],
                           bus.in_instr[25:21]};
`else
    logic unused_bits;

    // Without a predictor fetch effectively predicts not-taken.
    assign q_taken     = 1'b0;
    assign pred_eff    = 1'b0;
    assign unused_bits = ^{q_pc, pc_q, br_q, pop, bus.in_pred, bus.in_instr[25:21]};
`endif
endmodule

// File: tb/tb_br_resolve_unit.sv
// tb/tb_br_resolve_unit.sv - self-checking bench for br_resolve_unit
module tb_br_resolve_unit;
    localparam int DATA_W    = 32;
    localparam int BHT_DEPTH = 16;
`ifdef BR_RESOLVE_BHT_EN
    localparam bit BHT_EN = 1'b1;
`else
    localparam bit BHT_EN = 1'b0;
`endif

    typedef struct {
        logic        br;
        logic        taken;
        logic        mis;
        logic        link;
        logic [31:0] target;
        logic [31:0] pc;
    } res_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] q_pc  = 32'd0;
    logic        q_taken;

    int   errors = 0;
    int   checks = 0;
    bit   m_valid;
    res_t m_res;
    int   m_ctr [BHT_DEPTH];

    br_resolve_unit_if #(.DATA_W(DATA_W)) bus ();

    br_resolve_unit #(.DATA_W(DATA_W), .BHT_DEPTH(BHT_DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .flush  (flush),
        .q_pc   (q_pc),
        .q_taken(q_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd3, rt, imm};
    endfunction

    function automatic res_t ref_resolve(input logic [31:0] instr, input logic [31:0] pc, input logic pred,
                                         input logic [31:0] a, input logic [31:0] b);
        res_t r;
        int   sa;
        int   op;
        int   rt;
        int   off;
        sa  = int'($signed(a));
        op  = int'(instr[31:26]);
        rt  = int'(instr[20:16]);
        off = int'($signed(instr[15:0])) * 4;
        r.br = 1'b1; r.taken = 1'b0; r.link = 1'b0; r.pc = pc;
        case (op)
            4: r.taken = (a == b);
            5: r.taken = (a != b);
            6: r.taken = (sa <= 0);
            7: r.taken = (sa > 0);
            1: begin
                if (rt == 0) r.taken = (sa < 0);
                else if (rt == 1) r.taken = (sa >= 0);
                else if (rt == 17) begin r.taken = (sa >= 0); r.link = 1'b1; end
                else r.br = 1'b0;
            end
            default: r.br = 1'b0;
        endcase
        r.target = pc + 32'd4 + (r.taken ? 32'(off) : 32'd0);
        r.mis    = r.br && (r.taken != (BHT_EN ? pred : 1'b0));
        return r;
    endfunction

    function automatic logic exp_q(input logic [31:0] pc);
        return BHT_EN && (m_ctr[int'((pc >> 2) % BHT_DEPTH)] >= 2);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        for (int i = 0; i < BHT_DEPTH; i++) m_ctr[i] = 1;
    endtask

    task automatic drive(input bit vin, input logic [31:0] instr, input logic [31:0] pc, input bit pred,
                         input logic [31:0] a, input logic [31:0] b, input bit ordy, input bit fl);
        bus.in_valid  = vin;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.in_pred   = pred;
        bus.in_rdata1 = a;
        bus.in_rdata2 = b;
        bus.out_ready = ordy;
        flush         = fl;
        q_pc          = pc;
    endtask

    task automatic step();
        bit rdy;
        bit pop;
        int idx;
        rdy = !m_valid || bus.out_ready;
        pop = m_valid && bus.out_ready && !flush;
        idx = int'((m_res.pc >> 2) % BHT_DEPTH);
        if (pop && m_res.br && BHT_EN) begin
            if (m_res.taken) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
            else             m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end
        if (flush) m_valid = 1'b0;
        else if (rdy) begin
            m_valid = bus.in_valid;
            if (bus.in_valid)
                m_res = ref_resolve(bus.in_instr, bus.in_pc, bus.in_pred, bus.in_rdata1, bus.in_rdata2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(6'd4, 5'd0, 16'h0004), $urandom, 1'b1, 32'd7, 32'd7, 1'b1, 1'b0);
            @(negedge clk);
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", bus.out_valid); end
        checks++; if ({bus.out_taken, bus.out_mispredict, bus.out_link} !== 3'b000) begin
            errors++; $display("FAIL rst_flags: got %b exp 000", {bus.out_taken, bus.out_mispredict, bus.out_link}); end
        checks++; if (bus.out_target !== 32'd0) begin errors++; $display("FAIL rst_target: got %h exp 0", bus.out_target); end
        checks++; if (q_taken !== 1'b0) begin errors++; $display("FAIL rst_q_taken: got %b exp 0", q_taken); end
        reset = 1'b1;
        model_reset();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", bus.in_ready); end
        step();
    endtask

    task automatic test_bht_saturate();
        logic [31:0] beq_t;
        logic [31:0] beq_n;
        beq_t = mk(6'd4, 5'd0, 16'h0004);
        beq_n = mk(6'd4, 5'd0, 16'h0004);
        q_pc = 32'h3000; #1;
        checks++; if (q_taken !== 1'b0) begin errors++; $display("FAIL bht_init: got %b exp 0", q_taken); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, beq_t, 32'h3000, 1'b1, 32'd9, 32'd9, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 32'd0, 32'h3000, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        checks++; if (q_taken !== BHT_EN) begin errors++; $display("FAIL bht_two_pops: got %b exp %b", q_taken, BHT_EN); end
        step();
        drive(1'b1, beq_n, 32'h3000, 1'b1, 32'd1, 32'd2, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'h3000, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        #1;
        checks++; if (q_taken !== BHT_EN) begin errors++; $display("FAIL bht_saturate: got %b exp %b", q_taken, BHT_EN); end
    endtask

    task automatic test_beq();
        drive(1'b1, mk(6'd4, 5'd0, 16'h0004), 32'h3000, 1'b0, 32'h5, 32'h5, 1'b1, 1'b0);
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL beq_valid: got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b exp 1", bus.out_taken); end
        checks++; if (bus.out_target !== 32'h3014) begin errors++; $display("FAIL beq_target: got %h exp 3014", bus.out_target); end
        checks++; if (bus.out_mispredict !== 1'b1) begin errors++; $display("FAIL beq_mispredict: got %b exp 1", bus.out_mispredict); end
        drive(1'b0, 32'd0, 32'h5000, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_signed();
        drive(1'b1, mk(6'd1, 5'd0, 16'h0010), 32'h5000, 1'b1, 32'h80000000, 32'd0, 1'b1, 1'b0);
        step();
        checks++; if (bus.out_taken !== 1'b1) begin errors++; $display("FAIL bltz_taken: got %b exp 1", bus.out_taken); end
        checks++; if (bus.out_target !== 32'h5044) begin errors++; $display("FAIL bltz_target: got %h exp 5044", bus.out_target); end
        drive(1'b1, mk(6'd7, 5'd0, 16'h0010), 32'h5000, 1'b1, 32'h80000000, 32'd0, 1'b1, 1'b0);
        step();
        checks++; if (bus.out_taken !== 1'b0) begin errors++; $display("FAIL bgtz_taken: got %b exp 0", bus.out_taken); end
        checks++; if (bus.out_target !== 32'h5004) begin errors++; $display("FAIL bgtz_target: got %h exp 5004", bus.out_target); end
        drive(1'b0, 32'd0, 32'h5000, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_backpressure();
        drive(1'b1, mk(6'd5, 5'd0, 16'h0010), 32'h100, 1'b0, 32'd1, 32'd2, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(6'd4, 5'd0, 16'hFFFE), 32'h200, 1'b0, 32'd3, 32'd3, 1'b0, 1'b0);
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b exp 0", bus.in_ready); end
            step();
            checks++; if ({bus.out_valid, bus.out_taken, bus.out_target} !== {2'b11, 32'h144}) begin
                errors++; $display("FAIL bp_hold: got %b %b %h exp 1 1 144", bus.out_valid, bus.out_taken, bus.out_target); end
        end
        drive(1'b1, mk(6'd4, 5'd0, 16'hFFFE), 32'h200, 1'b0, 32'd3, 32'd3, 1'b1, 1'b0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b exp 1", bus.in_ready); end
        step();
        checks++; if ({bus.out_valid, bus.out_target} !== {1'b1, 32'h1FC}) begin
            errors++; $display("FAIL bp_second: got %b %h exp 1 1fc", bus.out_valid, bus.out_target); end
        drive(1'b1, mk(6'h23, 5'd0, 16'h0040), 32'h300, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        checks++; if ({bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_target} !== {3'b100, 32'h304}) begin
            errors++; $display("FAIL bp_third: got %b %b %b %h exp 1 0 0 304", bus.out_valid, bus.out_taken,
                               bus.out_mispredict, bus.out_target); end
        drive(1'b0, 32'd0, 32'h300, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, mk(6'd4, 5'd0, 16'h0004), 32'h3004, 1'b0, 32'd8, 32'd8, 1'b1, 1'b0);
        step();
        drive(1'b1, mk(6'd4, 5'd0, 16'h0004), 32'h3004, 1'b0, 32'd8, 32'd8, 1'b1, 1'b1);
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", bus.out_valid); end
        drive(1'b0, 32'd0, 32'h3004, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        #1;
        checks++; if (q_taken !== 1'b0) begin errors++; $display("FAIL flush_no_update: got %b exp 0", q_taken); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_bgezal();
        drive(1'b1, mk(6'd1, 5'd17, 16'h0008), 32'h4000, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
        step();
        checks++; if ({bus.out_taken, bus.out_link, bus.out_mispredict} !== 3'b010) begin
            errors++; $display("FAIL bgezal_flags: got %b exp 010", {bus.out_taken, bus.out_link, bus.out_mispredict}); end
        checks++; if (bus.out_target !== 32'h4004) begin errors++; $display("FAIL bgezal_target: got %h exp 4004", bus.out_target); end
        drive(1'b0, 32'd0, 32'h4000, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_reset_midtransfer();
        drive(1'b1, mk(6'd4, 5'd0, 16'h0004), 32'h3000, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        #1;
        checks++; if ({bus.out_valid, bus.out_target} !== 33'd0) begin
            errors++; $display("FAIL midrst_clear: got %b %h exp 0 0", bus.out_valid, bus.out_target); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drive(1'b0, 32'd0, 32'h3000, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b exp 1", bus.in_ready); end
        checks++; if (q_taken !== 1'b0) begin errors++; $display("FAIL midrst_bht: got %b exp 0", q_taken); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_random();
        logic [5:0]  ops [10] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd1, 6'd1, 6'd0, 6'h23, 6'h02};
        logic [4:0]  rts [5]  = '{5'd0, 5'd1, 5'd17, 5'd2, 5'd16};
        logic [31:0] spec [4] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        bit          ordy;
        for (int n = 0; n < 400; n++) begin
            a  = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
            pc = ($urandom_range(0, 7) == 0) ? $urandom : 32'h1000 + ($urandom_range(0, 31) << 2);
            ordy = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 4) != 0, mk(ops[$urandom_range(0, 9)], rts[$urandom_range(0, 4)], 16'($urandom)),
                  pc, 1'($urandom), a, b, ordy, $urandom_range(0, 19) == 0);
            if (m_valid && $urandom_range(0, 1) == 1) q_pc = m_res.pc;
            #1;
            checks++; if (bus.in_ready !== (!m_valid || ordy)) begin
                errors++; $display("FAIL rnd_in_ready: got %b exp %b cycle %0d", bus.in_ready, !m_valid || ordy, n); end
            checks++; if (q_taken !== exp_q(q_pc)) begin
                errors++; $display("FAIL rnd_q_taken: got %b exp %b pc %h", q_taken, exp_q(q_pc), q_pc); end
            step();
            checks++; if (bus.out_valid !== m_valid) begin
                errors++; $display("FAIL rnd_out_valid: got %b exp %b cycle %0d", bus.out_valid, m_valid, n); end
            if (m_valid) begin
                checks++;
                if ({bus.out_taken, bus.out_mispredict, bus.out_link, bus.out_target} !==
                    {m_res.taken, m_res.mis, m_res.link, m_res.target}) begin
                    errors++;
                    $display("FAIL rnd_result: got t%b m%b l%b %h exp t%b m%b l%b %h cycle %0d",
                             bus.out_taken, bus.out_mispredict, bus.out_link, bus.out_target,
                             m_res.taken, m_res.mis, m_res.link, m_res.target, n);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        m_res = '{br: 1'b0, taken: 1'b0, mis: 1'b0, link: 1'b0, target: 32'd0, pc: 32'd0};
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_bht_saturate();
        test_beq();
        test_signed();
        test_backpressure();
        test_flush();
        test_bgezal();
        test_reset_midtransfer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
